// File: rtl/l3_mem_write_buffer.sv
// l3_mem_write_buffer: posted-write buffer between an L3 cache and memory.
// Writebacks are acknowledged as soon as they are queued. Later they drain to
// memory in FIFO order whenever the upstream side is quiet. Refill reads
// bypass the queue unless they hit a buffered line.
// Optional feature macro: L3_WBUF_FWD_EN. When it is defined, a read that
// hits a buffered line is answered from the youngest matching entry. When it
// is undefined, the matching entries are drained first.
module l3_mem_write_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int LINE_W = 512
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     up_req_valid_i,
    output logic                     up_req_ready_o,
    input  logic                     up_req_write_i,
    input  logic [ADDR_W-1:0]        up_req_addr_i,
    input  logic [LINE_W-1:0]        up_req_data_i,
    output logic                     up_rsp_valid_o,
    input  logic                     up_rsp_ready_i,
    output logic [LINE_W-1:0]        up_rsp_data_o,
    output logic                     dn_req_valid_o,
    input  logic                     dn_req_ready_i,
    output logic                     dn_req_write_o,
    output logic [ADDR_W-1:0]        dn_req_addr_o,
    output logic [LINE_W-1:0]        dn_req_data_o,
    input  logic                     dn_rsp_valid_i,
    output logic                     dn_rsp_ready_o,
    input  logic [LINE_W-1:0]        dn_rsp_data_i,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [2:0] {
        IDLE, UP_RSP, RD_ISSUE, RD_WAIT, DR_ISSUE, DR_WAIT
    } state_t;

    state_t              state_reg, state_next;
    logic [CW-1:0]       count_reg;
    logic [PW-1:0]       head_reg, tail_reg;
    logic [ADDR_W-1:0]   rd_addr_reg;
    logic [LINE_W-1:0]   rsp_data_reg;

    // Entry storage: plain arrays without reset; validity comes from the
    // head pointer and the count.
    logic [ADDR_W-1:0]   addr_mem [DEPTH];
    logic [LINE_W-1:0]   data_mem [DEPTH];
    logic [LINE_W-1:0]   head_data_reg;

    logic [DEPTH-1:0]    match_vec;
    logic                any_match;
    logic                push, pop, rd_accept, rsp_load, rsp_clear;

`ifdef L3_WBUF_FWD_EN
    logic [PW-1:0]       rel_idx [DEPTH];
    logic [PW-1:0]       fwd_idx;
    logic                fwd_take;
    logic                fwd_sel_reg;
    logic [LINE_W-1:0]   fwd_data_reg;
`endif

    // Per-entry line-address compare. An entry is live if its distance from
    // the head is below the count.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [PW-1:0] offset;
            assign offset = PW'(gi) - head_reg;
            assign match_vec[gi] = ({1'b0, offset} < count_reg) &&
                (addr_mem[gi][ADDR_W-1:6] == up_req_addr_i[ADDR_W-1:6]);
`ifdef L3_WBUF_FWD_EN
            assign rel_idx[gi] = head_reg + PW'(gi);
`endif
        end
    endgenerate

    assign any_match = |match_vec;
    assign count_o   = count_reg;

`ifdef L3_WBUF_FWD_EN
    // Walk from oldest to youngest so that the last hit, the youngest, wins.
    always_comb begin
        fwd_idx = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (match_vec[rel_idx[k]]) fwd_idx = rel_idx[k];
        end
    end

    // The response mux is forced to 0 outside UP_RSP, so data reads 0 in reset.
    assign up_rsp_data_o = (state_reg != UP_RSP) ? '0 :
                           (fwd_sel_reg ? fwd_data_reg : rsp_data_reg);
`else
    assign up_rsp_data_o = (state_reg == UP_RSP) ? rsp_data_reg : '0;
`endif

    // Next-state logic and handshake outputs; every output defaults to idle.
    always_comb begin
        state_next     = state_reg;
        up_req_ready_o = 1'b0;
        up_rsp_valid_o = 1'b0;
        dn_req_valid_o = 1'b0;
        dn_req_write_o = 1'b0;
        dn_req_addr_o  = '0;
        dn_req_data_o  = '0;
        dn_rsp_ready_o = 1'b0;
        push           = 1'b0;
        pop            = 1'b0;
        rd_accept      = 1'b0;
        rsp_load       = 1'b0;
        rsp_clear      = 1'b0;
`ifdef L3_WBUF_FWD_EN
        fwd_take       = 1'b0;
`endif
        unique case (state_reg)
            IDLE: begin
                // rst_ni is part of the condition so that up_req_ready_o
                // drops in the same cycle that reset is asserted.
                if (up_req_valid_i && rst_ni) begin
                    if (up_req_write_i) begin
                        if (count_reg < CW'(DEPTH)) begin
                            up_req_ready_o = 1'b1;
                            push           = 1'b1;
                            rsp_clear      = 1'b1;
                            state_next     = UP_RSP;
                        end else begin
                            state_next = DR_ISSUE;
                        end
                    end else if (!any_match) begin
                        up_req_ready_o = 1'b1;
                        rd_accept      = 1'b1;
                        state_next     = RD_ISSUE;
                    end else begin
`ifdef L3_WBUF_FWD_EN
                        up_req_ready_o = 1'b1;
                        fwd_take       = 1'b1;
                        state_next     = UP_RSP;
`else
                        // A hit implies count>0, so a drain is always possible.
                        state_next = DR_ISSUE;
`endif
                    end
                end else if (count_reg != '0) begin
                    state_next = DR_ISSUE;
                end
            end
            UP_RSP: begin
                up_rsp_valid_o = 1'b1;
                if (up_rsp_ready_i) state_next = IDLE;
            end
            RD_ISSUE: begin
                dn_req_valid_o = 1'b1;
                dn_req_addr_o  = rd_addr_reg;
                if (dn_req_ready_i) state_next = RD_WAIT;
            end
            RD_WAIT: begin
                dn_rsp_ready_o = 1'b1;
                if (dn_rsp_valid_i) begin
                    rsp_load   = 1'b1;
                    state_next = UP_RSP;
                end
            end
            DR_ISSUE: begin
                dn_req_valid_o = 1'b1;
                dn_req_write_o = 1'b1;
                dn_req_addr_o  = addr_mem[head_reg];
                dn_req_data_o  = head_data_reg;
                if (dn_req_ready_i) state_next = DR_WAIT;
            end
            DR_WAIT: begin
                dn_rsp_ready_o = 1'b1;
                if (dn_rsp_valid_i) begin
                    pop        = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Control state, queue pointers and response data; reset drops everything.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg    <= IDLE;
            count_reg    <= '0;
            head_reg     <= '0;
            tail_reg     <= '0;
            rd_addr_reg  <= '0;
            rsp_data_reg <= '0;
`ifdef L3_WBUF_FWD_EN
            fwd_sel_reg  <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            if (push) begin
                tail_reg  <= tail_reg + PW'(1);
                count_reg <= count_reg + CW'(1);
            end
            if (pop) begin
                head_reg  <= head_reg + PW'(1);
                count_reg <= count_reg - CW'(1);
            end
            if (rd_accept) rd_addr_reg <= up_req_addr_i;
            if (rsp_clear)     rsp_data_reg <= '0;
            else if (rsp_load) rsp_data_reg <= dn_rsp_data_i;
`ifdef L3_WBUF_FWD_EN
            if (state_reg == IDLE) fwd_sel_reg <= fwd_take;
`endif
        end
    end

    // Storage writes and registered reads. head_data_reg follows the head
    // entry every cycle. Every path into DR_ISSUE passes through at least one
    // IDLE cycle after the last push or pop, so the register is current by
    // the time a drain is presented.
    always_ff @(posedge clk_i) begin
        if (push) begin
            addr_mem[tail_reg] <= up_req_addr_i;
            data_mem[tail_reg] <= up_req_data_i;
        end
        head_data_reg <= data_mem[head_reg];
`ifdef L3_WBUF_FWD_EN
        if (fwd_take) fwd_data_reg <= data_mem[fwd_idx];
`endif
    end

endmodule

// File: tb/tb_l3_mem_write_buffer.sv
// tb_l3_mem_write_buffer: directed self-checking bench for l3_mem_write_buffer.
// Inputs are driven just after the falling edge, and outputs are checked 1 time
// unit later. Matching-read expectations depend on L3_WBUF_FWD_EN.
module tb_l3_mem_write_buffer;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 32;
    localparam int LINE_W = 512;
    localparam int CW     = 3;

    localparam logic [LINE_W-1:0] D1 = {16{32'h1111_0001}};
    localparam logic [LINE_W-1:0] D2 = {16{32'h2222_0002}};
    localparam logic [LINE_W-1:0] D3 = {16{32'h3333_0003}};
    localparam logic [LINE_W-1:0] D4 = {16{32'h4444_0004}};
    localparam logic [LINE_W-1:0] D5 = {16{32'h5555_0005}};
    localparam logic [LINE_W-1:0] DB = {16{32'hBBBB_000B}};
    localparam logic [LINE_W-1:0] DC = {16{32'hCCCC_000C}};
    localparam logic [LINE_W-1:0] DD = {16{32'hDDDD_000D}};
    localparam logic [LINE_W-1:0] DE = {16{32'hEEEE_000E}};
    localparam logic [LINE_W-1:0] DF = {16{32'hFFFF_000F}};
    localparam logic [LINE_W-1:0] DZ = '0;

    logic              clk;
    logic              rst_n;
    logic              up_req_valid, up_req_ready, up_req_write;
    logic [ADDR_W-1:0] up_req_addr;
    logic [LINE_W-1:0] up_req_data;
    logic              up_rsp_valid, up_rsp_ready;
    logic [LINE_W-1:0] up_rsp_data;
    logic              dn_req_valid, dn_req_ready, dn_req_write;
    logic [ADDR_W-1:0] dn_req_addr;
    logic [LINE_W-1:0] dn_req_data;
    logic              dn_rsp_valid, dn_rsp_ready;
    logic [LINE_W-1:0] dn_rsp_data;
    logic [CW-1:0]     count;

    int checks   = 0;
    int failures = 0;

    l3_mem_write_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .up_req_valid_i(up_req_valid), .up_req_ready_o(up_req_ready),
        .up_req_write_i(up_req_write), .up_req_addr_i(up_req_addr),
        .up_req_data_i(up_req_data),
        .up_rsp_valid_o(up_rsp_valid), .up_rsp_ready_i(up_rsp_ready),
        .up_rsp_data_o(up_rsp_data),
        .dn_req_valid_o(dn_req_valid), .dn_req_ready_i(dn_req_ready),
        .dn_req_write_o(dn_req_write), .dn_req_addr_o(dn_req_addr),
        .dn_req_data_o(dn_req_data),
        .dn_rsp_valid_i(dn_rsp_valid), .dn_rsp_ready_o(dn_rsp_ready),
        .dn_rsp_data_i(dn_rsp_data),
        .count_o(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_b(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chk_c(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_a(input string tag, input logic [ADDR_W-1:0] obs, input logic [ADDR_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_d(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one write from IDLE, check ready, then the ack on the next cycle.
    // The task returns at the falling edge where the DUT is back in IDLE, and
    // the caller must drive the next request before the following rising edge.
    task automatic do_write(input logic [ADDR_W-1:0] a, input logic [LINE_W-1:0] d,
                            input logic [CW-1:0] exp_cnt);
        up_req_valid = 1'b1;
        up_req_write = 1'b1;
        up_req_addr  = a;
        up_req_data  = d;
        up_rsp_ready = 1'b1;
        #1;
        chk_b("wr_ready", up_req_ready, 1'b1);
        @(negedge clk); #1;
        chk_b("wr_ack_valid", up_rsp_valid, 1'b1);
        chk_d("wr_ack_data", up_rsp_data, DZ);
        chk_c("wr_count", count, exp_cnt);
        chk_b("wr_no_dn_req", dn_req_valid, 1'b0);
        chk_b("wr_busy_ready", up_req_ready, 1'b0);
        $display("write addr=%h count=%0d", a, count);
        @(negedge clk);
    endtask

    // Wait a bounded time for a drain, check it, optionally stall it, complete it.
    task automatic expect_drain(input logic [ADDR_W-1:0] a, input logic [LINE_W-1:0] d,
                                input logic [CW-1:0] exp_cnt, input int stall);
        int n;
        n = 0;
        #1;
        while (!dn_req_valid && n < 20) begin
            @(negedge clk); #1;
            n++;
        end
        chk_b("dr_seen", dn_req_valid, 1'b1);
        chk_b("dr_write", dn_req_write, 1'b1);
        chk_a("dr_addr", dn_req_addr, a);
        chk_d("dr_data", dn_req_data, d);
        for (int i = 0; i < stall; i++) begin
            @(negedge clk); #1;
            chk_b("dr_stall_valid", dn_req_valid, 1'b1);
            chk_a("dr_stall_addr", dn_req_addr, a);
            chk_d("dr_stall_data", dn_req_data, d);
        end
        dn_req_ready = 1'b1;
        @(negedge clk); #1;
        dn_req_ready = 1'b0;
        chk_b("dr_wait_rsp_ready", dn_rsp_ready, 1'b1);
        chk_b("dr_wait_no_req", dn_req_valid, 1'b0);
        dn_rsp_valid = 1'b1;
        @(negedge clk);
        dn_rsp_valid = 1'b0;
        #1;
        chk_c("dr_count", count, exp_cnt);
        $display("drain addr=%h count=%0d", a, count);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n        = 1'b0;
        up_req_valid = 1'b0;
        up_req_write = 1'b0;
        up_req_addr  = '0;
        up_req_data  = '0;
        up_rsp_ready = 1'b0;
        dn_req_ready = 1'b0;
        dn_rsp_valid = 1'b0;
        dn_rsp_data  = '0;

        // Outputs while reset is held.
        @(negedge clk); #1;
        chk_c("rst_count", count, 3'd0);
        chk_b("rst_up_req_ready", up_req_ready, 1'b0);
        chk_b("rst_up_rsp_valid", up_rsp_valid, 1'b0);
        chk_b("rst_dn_req_valid", dn_req_valid, 1'b0);
        chk_b("rst_dn_rsp_ready", dn_rsp_ready, 1'b0);
        chk_d("rst_up_rsp_data", up_rsp_data, DZ);
        chk_d("rst_dn_req_data", dn_req_data, DZ);
        $display("reset checked");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Four writes fill the buffer with no drain while requests keep coming.
        do_write(32'h0000_1000, D1, 3'd1);
        do_write(32'h0000_1100, D2, 3'd2);
        do_write(32'h0000_1200, D3, 3'd3);
        do_write(32'h0000_1300, D4, 3'd4);

        // The fifth write stalls, the head drains (with a stall), then the write is accepted.
        up_req_addr = 32'h0000_1400;
        up_req_data = D5;
        #1;
        chk_b("full_ready", up_req_ready, 1'b0);
        expect_drain(32'h0000_1000, D1, 3'd3, 2);
        chk_b("wr5_ready", up_req_ready, 1'b1);
        @(negedge clk); #1;
        chk_b("wr5_ack", up_rsp_valid, 1'b1);
        chk_c("wr5_count", count, 3'd4);
        up_req_valid = 1'b0;
        @(negedge clk);

        // The rest drain in FIFO order.
        expect_drain(32'h0000_1100, D2, 3'd3, 0);
        expect_drain(32'h0000_1200, D3, 3'd2, 0);
        expect_drain(32'h0000_1300, D4, 3'd1, 1);
        expect_drain(32'h0000_1400, D5, 3'd0, 0);

        // A non-matching read bypasses a buffered write.
        do_write(32'h0000_2000, DB, 3'd1);
        up_req_write = 1'b0;
        up_req_addr  = 32'h0000_3000;
        #1;
        chk_b("rd_ready", up_req_ready, 1'b1);
        @(negedge clk); #1;
        chk_b("rd_dn_valid", dn_req_valid, 1'b1);
        chk_b("rd_dn_write", dn_req_write, 1'b0);
        chk_a("rd_dn_addr", dn_req_addr, 32'h0000_3000);
        chk_c("rd_count", count, 3'd1);
        up_req_valid = 1'b0;
        dn_req_ready = 1'b1;
        @(negedge clk); #1;
        dn_req_ready = 1'b0;
        chk_b("rd_wait_rsp_ready", dn_rsp_ready, 1'b1);
        dn_rsp_valid = 1'b1;
        dn_rsp_data  = DE;
        up_rsp_ready = 1'b0;
        @(negedge clk); #1;
        dn_rsp_valid = 1'b0;
        dn_rsp_data  = '0;
        chk_b("rd_rsp_valid", up_rsp_valid, 1'b1);
        chk_d("rd_rsp_data", up_rsp_data, DE);
        @(negedge clk); #1;
        chk_b("rd_rsp_stall_valid", up_rsp_valid, 1'b1);
        chk_d("rd_rsp_stall_data", up_rsp_data, DE);
        $display("read addr=3000 returned data");
        up_rsp_ready = 1'b1;
        @(negedge clk);
        expect_drain(32'h0000_2000, DB, 3'd0, 0);

        // Duplicate writes to 0x4000, then a matching read.
        @(negedge clk);
        do_write(32'h0000_4000, DC, 3'd1);
        do_write(32'h0000_4000, DD, 3'd2);
        up_req_write = 1'b0;
        up_req_addr  = 32'h0000_4000;
`ifdef L3_WBUF_FWD_EN
        #1;
        chk_b("fwd_ready", up_req_ready, 1'b1);
        @(negedge clk); #1;
        chk_b("fwd_rsp_valid", up_rsp_valid, 1'b1);
        chk_d("fwd_rsp_data", up_rsp_data, DD);
        chk_b("fwd_no_dn", dn_req_valid, 1'b0);
        chk_c("fwd_count", count, 3'd2);
        $display("forwarded read addr=4000");
        up_req_valid = 1'b0;
        @(negedge clk);
        expect_drain(32'h0000_4000, DC, 3'd1, 0);
        expect_drain(32'h0000_4000, DD, 3'd0, 0);
`else
        #1;
        chk_b("hit_ready", up_req_ready, 1'b0);
        expect_drain(32'h0000_4000, DC, 3'd1, 0);
        chk_b("hit_ready_after_c", up_req_ready, 1'b0);
        expect_drain(32'h0000_4000, DD, 3'd0, 0);
        chk_b("hit_ready_after_d", up_req_ready, 1'b1);
        @(negedge clk); #1;
        chk_b("hit_dn_valid", dn_req_valid, 1'b1);
        chk_b("hit_dn_write", dn_req_write, 1'b0);
        chk_a("hit_dn_addr", dn_req_addr, 32'h0000_4000);
        up_req_valid = 1'b0;
        dn_req_ready = 1'b1;
        @(negedge clk); #1;
        dn_req_ready = 1'b0;
        dn_rsp_valid = 1'b1;
        dn_rsp_data  = DF;
        @(negedge clk); #1;
        dn_rsp_valid = 1'b0;
        chk_b("hit_rsp_valid", up_rsp_valid, 1'b1);
        chk_d("hit_rsp_data", up_rsp_data, DF);
        $display("read after drain addr=4000");
        @(negedge clk);
`endif

        // Reset in DR_WAIT with three entries buffered.
        @(negedge clk);
        do_write(32'h0000_5000, D1, 3'd1);
        do_write(32'h0000_5040, D2, 3'd2);
        do_write(32'h0000_5080, D3, 3'd3);
        up_req_valid = 1'b0;
        begin
            int n;
            n = 0;
            #1;
            while (!dn_req_valid && n < 20) begin
                @(negedge clk); #1;
                n++;
            end
        end
        chk_a("rst_dr_addr", dn_req_addr, 32'h0000_5000);
        dn_req_ready = 1'b1;
        @(negedge clk); #1;
        dn_req_ready = 1'b0;
        chk_c("rst_pre_count", count, 3'd3);
        chk_b("rst_pre_rsp_ready", dn_rsp_ready, 1'b1);
        up_req_valid = 1'b1;
        up_req_write = 1'b1;
        rst_n = 1'b0;
        #1;
        chk_c("rst_mid_count", count, 3'd0);
        chk_b("rst_mid_rsp_ready", dn_rsp_ready, 1'b0);
        chk_b("rst_mid_dn_valid", dn_req_valid, 1'b0);
        chk_b("rst_mid_up_rsp_valid", up_rsp_valid, 1'b0);
        chk_b("rst_mid_up_req_ready", up_req_ready, 1'b0);
        $display("reset during drain checked");
        up_req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk); #1;
        chk_c("post_rst_count", count, 3'd0);
        chk_b("post_rst_no_drain", dn_req_valid, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
